cache_write_buffer: RTL and testbench
=====================================

Name: cache_write_buffer

Overview:
- Write-direction companion to the cache/RAM read-fill path.
- Accepts 32-bit CPU stores (10-bit word address) into a small FIFO and drains them one word at a time into the RAM write port with a ready handshake.
- After each completed RAM write, pulses an invalidate to the cache so the stale 128-bit line is refetched.
- Provides store-to-load forwarding of buffered data so reads never observe RAM older than a pending store.

Parameters:
- DEPTH, 4, number of buffered store entries (power of 2, 2..16)
- AW, 10, word address width
- DW, 32, data width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- wr_valid  in  1  CPU store request
- wr_addr  in  AW  store word address
- wr_data  in  DW  store data
- wr_ready  out  1  buffer can accept a store this cycle
- rd_addr  in  AW  load address for forwarding lookup
- fwd_hit  out  1  a buffered entry matches rd_addr
- fwd_data  out  DW  data of youngest matching entry
- ram_addr  out  AW  RAM write address (head entry)
- ram_write_data  out  DW  RAM write data (head entry)
- ram_mem_write  out  1  RAM write request
- ram_ready  in  1  RAM accepts write this cycle
- inval_valid  out  1  one-cycle cache line invalidate pulse
- inval_index  out  AW-2  line index (addr[AW-1:2]) to invalidate
- empty  out  1  no buffered entries and drain FSM idle

Behaviour:
- Storage: circular FIFO of DEPTH {addr,data}; wr_ptr, rd_ptr wrap modulo DEPTH; count 0..DEPTH.
- Push: on an edge with reset=1 and wr_valid&&wr_ready, the entry is written at wr_ptr and wr_ptr advances.
- wr_ready = reset && (count != DEPTH), combinational. There is no full-bypass: when full, wr_ready=0 even if a pop occurs in the same cycle.
- Drain FSM states: IDLE, ISSUE.
  - IDLE -> ISSUE on an edge where count != 0.
  - In ISSUE: ram_mem_write=1; ram_addr/ram_write_data driven from the rd_ptr entry and held stable until accepted.
  - Accept = ISSUE && ram_ready at an edge. On accept: pop (rd_ptr++), set inval_valid=1 and inval_index=popped addr[AW-1:2] for exactly the next cycle.
  - After accept: stay ISSUE if count_next != 0, else go to IDLE. Back-to-back accepts are allowed, one per cycle.
- ram_mem_write=0 and ram_addr/ram_write_data=0 in IDLE.
- Latency: a store accepted at edge E raises ram_mem_write in the cycle after edge E+1 (two edges, buffer initially empty and idle).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Ordering: strict FIFO; RAM writes occur in acceptance order, including repeated addresses. No write merging.
- Forwarding (combinational):
  - Compare rd_addr against all valid stored entries; fwd_hit=1 if any match; fwd_data = youngest match (closest to wr_ptr).
  - The head entry remains valid for forwarding until the edge that accepts it.
  - A store presented in the same cycle is not visible to forwarding.
  - fwd_data=0 when fwd_hit=0.
- empty = (count==0) && state==IDLE.
- Reset (reset=0 at an edge):
  - count=0, pointers=0, state=IDLE.
  - ram_mem_write=0, inval_valid=0, inval_index=0, fwd_hit=0, empty=1.
  - Reset mid-drain discards all pending entries; no further RAM writes are issued.
  - While reset=0, wr_ready=0.

Test Plan:
- Reset then single store: wr_addr=0x05C, wr_data=0xDEADBEEF, ram_ready=1. Expect ram_mem_write high two edges later with ram_addr=0x05C, data 0xDEADBEEF; then inval_valid one cycle with inval_index=0x17; then empty=1.
- Fill to full: 4 stores with ram_ready=0. Expect wr_ready=0 after the 4th; a 5th wr_valid is ignored. Raise ram_ready: 4 back-to-back writes in order; wr_ready returns to 1 after the first accept.
- RAM stall: hold ram_ready=0 for 5 cycles during ISSUE. Expect ram_addr/ram_write_data unchanged and no inval_valid; single accept on ram_ready=1.
- Forwarding: store 0x010<-0x11111111, then 0x010<-0x22222222, ram_ready=0; rd_addr=0x010 -> fwd_hit=1, fwd_data=0x22222222. Drain both -> fwd_hit=0.
- Simultaneous push/pop at count=2: count stays 2, order preserved. Wrap-around over 10 stores: RAM sees all 10 in order.
- Mid-drain reset with 3 entries pending: ram_mem_write=0 next cycle, empty=1, no inval_valid; a subsequent store drains normally.

Source files
------------

// File: rtl/cache_write_buffer.sv
// Store FIFO draining into the RAM write port with a per-write cache-line invalidate and store-to-load forwarding.
// Latency: a store reaches ram_mem_write two edges after it is accepted. Backpressure: wr_ready drops when full; the head holds until ram_ready.
module cache_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_write_data,
  output logic          ram_mem_write,
  input  logic          ram_ready,
  output logic          inval_valid,
  output logic [AW-3:0] inval_index,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t        state;
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_next;
  logic [PW-1:0] idx;
  logic          push;
  logic          pop;

  assign wr_ready       = reset && (count != (PW+1)'(DEPTH));
  assign push           = wr_valid && wr_ready;
  assign pop            = (state == ISSUE) && ram_ready;
  assign count_next     = count + (PW+1)'(push) - (PW+1)'(pop);
  assign ram_mem_write  = (state == ISSUE);
  assign ram_addr       = ram_mem_write ? addr_mem[rd_ptr] : '0;
  assign ram_write_data = ram_mem_write ? data_mem[rd_ptr] : '0;
  assign empty          = (count == '0) && (state == IDLE);

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (((PW+1)'(i) < count) && (addr_mem[idx] == rd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= wr_addr;
      data_mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      state       <= IDLE;
      inval_valid <= 1'b0;
      inval_index <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + PW'(1);
        inval_index <= addr_mem[rd_ptr][AW-1:2];
      end
      inval_valid <= pop;
      count       <= count_next;
      case (state)
        IDLE:    if (count != '0) state <= ISSUE;
        ISSUE:   if (pop && (count_next == '0)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed plus random stimulus against a queue-based model of the store buffer.
module tb_cache_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] rd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_write_data;
  logic          ram_mem_write;
  logic          ram_ready;
  logic          inval_valid;
  logic [AW-3:0] inval_index;
  logic          empty;

  cache_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .ram_addr(ram_addr), .ram_write_data(ram_write_data), .ram_mem_write(ram_mem_write),
    .ram_ready(ram_ready), .inval_valid(inval_valid), .inval_index(inval_index),
    .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  bit            issuing;
  bit            inv_exp;
  logic [AW-3:0] inv_idx;
  int            errors = 0;
  int            checks = 0;
  int            writes_seen = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit            hit;
    logic [DW-1:0] fd;
    hit = 1'b0;
    fd  = '0;
    foreach (q[i]) if (q[i].a == rd_addr) begin hit = 1'b1; fd = q[i].d; end
    chk("wr_ready", wr_ready, reset && (q.size() != DEPTH));
    chk("ram_mem_write", ram_mem_write, issuing);
    if (issuing) begin
      chk("ram_addr", ram_addr, q[0].a);
      chk("ram_write_data", ram_write_data, q[0].d);
    end else begin
      chk("ram_addr_idle", ram_addr, '0);
      chk("ram_data_idle", ram_write_data, '0);
    end
    chk("inval_valid", inval_valid, inv_exp);
    if (inv_exp) chk("inval_index", inval_index, inv_idx);
    chk("fwd_hit", fwd_hit, hit);
    chk("fwd_data", fwd_data, fd);
    chk("empty", empty, (q.size() == 0) && !issuing);
  endtask

  // Called 1 time unit after a rising edge; checks, then advances the model across the next edge.
  task automatic cyc();
    bit push, acc;
    int pre;
    #3;
    check_outputs();
    push = reset && wr_valid && (q.size() != DEPTH);
    acc  = reset && issuing && ram_ready;
    pre  = q.size();
    @(posedge clk);
    if (!reset) begin
      q.delete();
      issuing = 1'b0;
      inv_exp = 1'b0;
    end else begin
      inv_exp = acc;
      if (acc) begin
        inv_idx = q[0].a[AW-1:2];
        void'(q.pop_front());
        writes_seen++;
      end
      if (push) q.push_back('{wr_addr, wr_data});
      if (issuing) issuing = (q.size() != 0);
      else         issuing = (pre != 0);
    end
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    cyc();
    wr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; ram_ready = 1'b0;
    issuing = 1'b0; inv_exp = 1'b0; inv_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    #3;
    chk("rst_empty", empty, 1'b1);
    chk("rst_mem_write", ram_mem_write, 1'b0);
    chk("rst_inval_valid", inval_valid, 1'b0);
    chk("rst_inval_index", inval_index, '0);
    chk("rst_fwd_hit", fwd_hit, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single store, then drain with ram_ready high.
    ram_ready = 1'b1;
    store(10'h05C, 32'hDEADBEEF);
    repeat (5) cyc();
    chk("single_inval_idx_value", inv_idx, 8'h17);

    // Fill to full with RAM stalled; the fifth store must be dropped.
    ram_ready = 1'b0;
    for (int i = 0; i < 5; i++) store(10'h100 + 10'(i), 32'hA000_0000 + i);
    repeat (5) cyc();
    ram_ready = 1'b1;
    repeat (7) cyc();
    chk("full_drain_count", writes_seen, 5);

    // Stall on a single entry for several cycles.
    ram_ready = 1'b0;
    store(10'h2A4, 32'h1234_5678);
    repeat (6) cyc();
    ram_ready = 1'b1;
    repeat (3) cyc();

    // Forwarding returns the youngest of two stores to the same address.
    ram_ready = 1'b0;
    rd_addr = 10'h010;
    store(10'h010, 32'h1111_1111);
    store(10'h010, 32'h2222_2222);
    cyc();
    chk("fwd_youngest", fwd_data, 32'h2222_2222);
    ram_ready = 1'b1;
    repeat (4) cyc();
    chk("fwd_after_drain", fwd_hit, 1'b0);

    // Push and pop together at count 2, then ten stores across the pointer wrap.
    ram_ready = 1'b0;
    store(10'h031, 32'h3100_0001);
    store(10'h032, 32'h3200_0002);
    cyc();
    ram_ready = 1'b1;
    for (int i = 0; i < 10; i++) store(10'h040 + 10'(i), 32'hC0DE_0000 + i);
    repeat (6) cyc();
    chk("wrap_drain_count", writes_seen, 20);

    // Reset with three entries pending discards them.
    ram_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(10'h300 + 10'(i), 32'hBAD0_0000 + i);
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    ram_ready = 1'b1;
    repeat (3) cyc();
    store(10'h3F0, 32'h600D_600D);
    repeat (5) cyc();

    // Random traffic over a small address range so forwarding hits often.
    for (int n = 0; n < 400; n++) begin
      wr_valid  = ($urandom_range(0, 1) == 1);
      wr_addr   = 10'($urandom_range(0, 7));
      wr_data   = $urandom;
      rd_addr   = 10'($urandom_range(0, 7));
      ram_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 59) != 0);
      cyc();
    end
    wr_valid = 1'b0; reset = 1'b1; ram_ready = 1'b1;
    repeat (8) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
